mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: XLEN, default 64, data/address width; STARVE_LIMIT, default 4, fetch starvation threshold.
REQ-002 SHALL have ports, one per line below:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- dbg_req / dbg_we  in  1 / 1  debug request / write strobe
- dbg_addr / dbg_wdata  in  XLEN / XLEN  debug address / write data
- dbg_ready / dbg_done  out  1 / 1  debug accept / completion pulse
- dm_req / dm_we  in  1 / 1  data-memory request / write strobe
- dm_addr / dm_wdata  in  XLEN / XLEN  data address / write data
- dm_ready / dm_rvalid  out  1 / 1  data accept / response pulse
- dm_rdata  out  XLEN  data response
- if_req  in  1  fetch read request
- if_addr  in  XLEN  fetch address
- if_ready / if_rvalid  out  1 / 1  fetch accept / response pulse
- if_rdata  out  XLEN  fetch response
- mem_req / mem_we  out  1 / 1  shared memory request / write
- mem_addr / mem_wdata  out  XLEN / XLEN  shared memory address / write data
- mem_ack  in  1  memory completion, variable latency
- mem_rdata  in  XLEN  memory read data, valid with mem_ack
- busy  out  1  transaction in flight
- grant_id  out  2  owner: 0 none, 1 dbg, 2 dm, 3 if

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-004 SHALL arbitrate only in IDLE, from same-cycle req levels.
REQ-005 SHALL use priority dbg > if (boosted) > dm > if (normal).
REQ-006 SHALL treat fetch as boosted when the starve counter equals STARVE_LIMIT.
REQ-007 SHALL assert, in IDLE, exactly one combinational ready to the winner for one cycle, latch owner/we/addr/wdata (if: we=0, wdata=0), and go to BUSY.
REQ-008 SHALL assert no ready outside IDLE, and none in IDLE with no requests.
REQ-009 SHALL, in BUSY, hold mem_req=1 with latched mem_we/mem_addr/mem_wdata stable until mem_ack.
REQ-010 SHALL, on mem_ack in BUSY, register mem_rdata (reads) or zero (writes) into the owner's rdata and go to RESP.
REQ-011 SHALL, in RESP, pulse the owner's rvalid (dm/if) or dbg_done for exactly one cycle, reads and writes alike, then return to IDLE.
REQ-012 SHALL hold dm_rdata/if_rdata until that port's next response.
REQ-013 SHALL ignore mem_ack in IDLE and RESP.
REQ-014 SHALL give latency accept(N) -> mem_req from N+1 -> ack at N+k (k>=1) -> rvalid at N+k+1 -> next ready earliest N+k+2.
REQ-015 SHALL increment the starve counter on each IDLE arbitration cycle with if_req=1 and fetch not granted, saturating at STARVE_LIMIT.
REQ-016 SHALL clear the starve counter when fetch is granted.
REQ-017 SHALL drive busy=1 in BUSY and RESP.
REQ-018 SHALL hold grant_id at the owner from BUSY through RESP, and at 0 in IDLE.
REQ-019 SHALL treat a req dropped before ready as no transaction, with no side effects.
REQ-020 SHALL drive mem_req=0 and mem_we=0 whenever not in BUSY.

Reset
REQ-021 SHALL, on rst (any state, including mid-BUSY), go to IDLE and zero every output, latch and the starve counter next cycle.
REQ-022 SHALL ignore a mem_ack arriving after reset for a transaction aborted by reset.

Verification
REQ-023 Single dm read addr 0x40, mem_ack 3 cycles later with rdata 0xDEAD -> dm_ready at N, mem_req N+1..N+3, dm_rvalid=1, dm_rdata=0xDEAD at N+4.
REQ-024 dbg, dm, if requesting together -> grant order dbg, dm, then if; dbg_done pulses once; grant_id 1, 2, 3.
REQ-025 dm_req held high, if_req high, STARVE_LIMIT=4 -> dm wins 4 arbitrations, fetch wins the 5th, counter returns to 0.
REQ-026 dm write addr 0x80 data 0x1234 -> mem_we=1, mem_wdata=0x1234 stable until ack; dm_rvalid pulses with dm_rdata=0.
REQ-027 rst asserted during BUSY, then mem_ack -> mem_req=0, busy=0, no rvalid; next if request serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one variable-latency memory port between three requesters:
// debug (dbg), data memory (dm) and instruction fetch (if).
//
// Handshake semantics (all requester ports):
//   A requester raises *_req with its command fields valid and holds them
//   until it sees *_ready high in the same cycle.  *_ready is combinational,
//   is only ever high in IDLE and is high for exactly one requester.  The
//   transfer happens on the rising edge where req && ready.  Dropping req
//   before ready means no transaction.  The completion (dm_rvalid, if_rvalid
//   or dbg_done) is a single-cycle pulse, issued for reads and writes alike.
//   On the memory side mem_req/mem_we/mem_addr/mem_wdata are held stable
//   while in BUSY until the memory answers with a one-cycle mem_ack.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   dbg_req/we/addr/wdata          debug command in
//   dbg_ready, dbg_done            debug accept / completion pulse
//   dm_req/we/addr/wdata           data command in
//   dm_ready, dm_rvalid, dm_rdata  data accept / response pulse / data
//   if_req, if_addr                fetch read command in
//   if_ready, if_rvalid, if_rdata  fetch accept / response pulse / data
//   mem_req/we/addr/wdata          shared memory command out
//   mem_ack, mem_rdata             memory completion / read data
//   busy                           a transaction is in flight
//   grant_id                       owner: 0 none, 1 dbg, 2 dm, 3 if
//
// Priority is dbg > boosted fetch > dm > fetch.  Fetch becomes boosted once
// it has lost STARVE_LIMIT arbitrations while requesting.  The FSM state is
// visible on the internal signal state_q for checkers.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [XLEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ready,
    output logic            dbg_done,

    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_ready,
    output logic            dm_rvalid,
    output logic [XLEN-1:0] dm_rdata,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ready,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            busy,
    output logic [1:0]      grant_id
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DBG  = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;
    localparam logic [1:0] OWN_IF   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        owner_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   dm_rdata_q;
    logic [XLEN-1:0]   if_rdata_q;
    logic [CW-1:0]     starve_q;

    logic              if_boost;
    logic [1:0]        winner;

    // Arbitration from this cycle's request levels; only meaningful in IDLE.
    always_comb begin
        if_boost = (starve_q == CW'(STARVE_LIMIT));
        winner   = OWN_NONE;
        if (state_q == IDLE) begin
            if (dbg_req)                 winner = OWN_DBG;
            else if (if_req && if_boost) winner = OWN_IF;
            else if (dm_req)             winner = OWN_DM;
            else if (if_req)             winner = OWN_IF;
        end
    end

    // Next state and outputs.
    always_comb begin
        state_d   = state_q;
        dbg_ready = 1'b0;
        dm_ready  = 1'b0;
        if_ready  = 1'b0;
        dbg_done  = 1'b0;
        dm_rvalid = 1'b0;
        if_rvalid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        grant_id  = OWN_NONE;

        case (state_q)
            IDLE: begin
                dbg_ready = (winner == OWN_DBG);
                dm_ready  = (winner == OWN_DM);
                if_ready  = (winner == OWN_IF);
                if (winner != OWN_NONE) state_d = BUSY;
            end
            BUSY: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                busy     = 1'b1;
                grant_id = owner_q;
                if (mem_ack) state_d = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                grant_id  = owner_q;
                dbg_done  = (owner_q == OWN_DBG);
                dm_rvalid = (owner_q == OWN_DM);
                if_rvalid = (owner_q == OWN_IF);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_rdata  = if_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dm_rdata_q <= '0;
            if_rdata_q <= '0;
            starve_q   <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE) begin
                // Latch the accepted command; fetch is always a read.
                case (winner)
                    OWN_DBG: begin
                        owner_q <= OWN_DBG;
                        we_q    <= dbg_we;
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                    end
                    OWN_DM: begin
                        owner_q <= OWN_DM;
                        we_q    <= dm_we;
                        addr_q  <= dm_addr;
                        wdata_q <= dm_wdata;
                    end
                    OWN_IF: begin
                        owner_q <= OWN_IF;
                        we_q    <= 1'b0;
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                    end
                    default: ;
                endcase

                // Starvation tracking: count lost arbitrations, saturate.
                if (winner == OWN_IF)
                    starve_q <= '0;
                else if (if_req && (starve_q != CW'(STARVE_LIMIT)))
                    starve_q <= starve_q + CW'(1);
            end

            // Writes return zero so a response always carries defined data.
            if ((state_q == BUSY) && mem_ack) begin
                if (owner_q == OWN_DM) dm_rdata_q <= we_q ? '0 : mem_rdata;
                if (owner_q == OWN_IF) if_rdata_q <= we_q ? '0 : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (XLEN=64, STARVE_LIMIT=4).  Inputs are
// driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            dbg_req, dbg_we;
    logic [XLEN-1:0] dbg_addr, dbg_wdata;
    logic            dbg_ready, dbg_done;
    logic            dm_req, dm_we;
    logic [XLEN-1:0] dm_addr, dm_wdata;
    logic            dm_ready, dm_rvalid;
    logic [XLEN-1:0] dm_rdata;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ready, if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            busy;
    logic [1:0]      grant_id;

    int n_checks = 0;
    int n_fail   = 0;
    int dbg_done_cnt = 0;

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_done(dbg_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) if (dbg_done) dbg_done_cnt++;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in IDLE with requests already driven: checks the ready vector
    // {dbg,dm,if}, then steps across the accepting edge.
    task automatic accept(input logic [2:0] exp_rdy);
        #1;
        check("ready_vec", {61'd0, dbg_ready, dm_ready, if_ready}, {61'd0, exp_rdy});
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_grant", {62'd0, grant_id}, 64'd0);
        @(posedge clk); #1;
    endtask

    // Called in the first BUSY cycle.  Memory answers on the k-th BUSY cycle.
    task automatic run_txn(input logic [1:0] exp_id, input int k, input logic exp_we,
                           input logic [XLEN-1:0] exp_addr, input logic [XLEN-1:0] exp_wdata,
                           input logic [XLEN-1:0] rd, input logic [XLEN-1:0] exp_rdata);
        for (int c = 1; c <= k; c++) begin
            if (c == k) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            #1;
            check("busy_mem_req", {63'd0, mem_req}, 64'd1);
            check("busy_mem_we", {63'd0, mem_we}, {63'd0, exp_we});
            check("busy_mem_addr", mem_addr, exp_addr);
            check("busy_mem_wdata", mem_wdata, exp_wdata);
            check("busy_grant", {62'd0, grant_id}, {62'd0, exp_id});
            check("busy_ready_vec", {61'd0, dbg_ready, dm_ready, if_ready}, 64'd0);
            @(posedge clk); #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = 64'hBADBAD;
        #1;
        check("resp_mem_req", {63'd0, mem_req}, 64'd0);
        check("resp_busy", {63'd0, busy}, 64'd1);
        check("resp_grant", {62'd0, grant_id}, {62'd0, exp_id});
        check("resp_ready_vec", {61'd0, dbg_ready, dm_ready, if_ready}, 64'd0);
        check("resp_pulses", {61'd0, dbg_done, dm_rvalid, if_rvalid},
              {61'd0, exp_id == 2'd1, exp_id == 2'd2, exp_id == 2'd3});
        if (exp_id == 2'd2) check("resp_dm_rdata", dm_rdata, exp_rdata);
        if (exp_id == 2'd3) check("resp_if_rdata", if_rdata, exp_rdata);
        @(posedge clk); #1;
        #1;
        check("after_pulses", {61'd0, dbg_done, dm_rvalid, if_rvalid}, 64'd0);
        check("after_busy", {63'd0, busy}, 64'd0);
        check("after_grant", {62'd0, grant_id}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        if_req = 0; if_addr = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        // Reset state
        check("rst_ready_vec", {61'd0, dbg_ready, dm_ready, if_ready}, 64'd0);
        check("rst_pulses", {61'd0, dbg_done, dm_rvalid, if_rvalid}, 64'd0);
        check("rst_mem", {62'd0, mem_req, mem_we}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_grant", {62'd0, grant_id}, 64'd0);
        check("rst_dm_rdata", dm_rdata, 64'd0);
        check("rst_if_rdata", if_rdata, 64'd0);

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 64'h5555;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        check("idle_ack_busy", {63'd0, busy}, 64'd0);
        check("idle_ack_dm_rdata", dm_rdata, 64'd0);
        @(posedge clk); #1;

        // Single dm read, ack on the 3rd BUSY cycle
        dm_req = 1; dm_we = 0; dm_addr = 64'h40;
        accept(3'b010);
        dm_req = 0; dm_addr = 0;
        run_txn(2'd2, 3, 1'b0, 64'h40, 64'd0, 64'hDEAD, 64'hDEAD);

        // All three request together: dbg, dm, then if
        dbg_req = 1; dbg_we = 1; dbg_addr = 64'h10; dbg_wdata = 64'h55;
        dm_req = 1; dm_we = 0; dm_addr = 64'h20;
        if_req = 1; if_addr = 64'h30;
        accept(3'b100);
        dbg_req = 0; dbg_we = 0;
        run_txn(2'd1, 1, 1'b1, 64'h10, 64'h55, 64'h9999, 64'd0);
        accept(3'b010);
        dm_req = 0;
        run_txn(2'd2, 2, 1'b0, 64'h20, 64'd0, 64'h1111, 64'h1111);
        accept(3'b001);
        if_req = 0;
        run_txn(2'd3, 1, 1'b0, 64'h30, 64'd0, 64'h2222, 64'h2222);
        check("dbg_done_once", 64'(dbg_done_cnt), 64'd1);

        // Starvation: dm wins 4 times, fetch wins the 5th, counter cleared
        dm_req = 1; dm_we = 0; dm_addr = 64'h50;
        if_req = 1; if_addr = 64'h60;
        for (int i = 0; i < 4; i++) begin
            accept(3'b010);
            run_txn(2'd2, 1, 1'b0, 64'h50, 64'd0, 64'(i + 100), 64'(i + 100));
        end
        accept(3'b001);
        run_txn(2'd3, 1, 1'b0, 64'h60, 64'd0, 64'h3333, 64'h3333);
        accept(3'b010);
        run_txn(2'd2, 2, 1'b0, 64'h50, 64'd0, 64'h4444, 64'h4444);
        dm_req = 0;
        accept(3'b001);
        if_req = 0;
        run_txn(2'd3, 1, 1'b0, 64'h60, 64'd0, 64'h6666, 64'h6666);

        // dm write: command fields latched, response data is zero
        dm_req = 1; dm_we = 1; dm_addr = 64'h80; dm_wdata = 64'h1234;
        accept(3'b010);
        dm_req = 0; dm_we = 0; dm_addr = 64'hFFF; dm_wdata = 64'hFFFF;
        run_txn(2'd2, 3, 1'b1, 64'h80, 64'h1234, 64'hBEEF, 64'd0);
        check("if_rdata_held", if_rdata, 64'h6666);
        check("dm_rdata_held", dm_rdata, 64'd0);

        // Reset mid-BUSY, late ack ignored, then a normal fetch
        dm_req = 1; dm_we = 0; dm_addr = 64'h90;
        accept(3'b010);
        dm_req = 0;
        #1 check("pre_rst_mem_req", {63'd0, mem_req}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_busy_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_busy_busy", {63'd0, busy}, 64'd0);
        check("rst_busy_grant", {62'd0, grant_id}, 64'd0);
        check("rst_busy_if_rdata", if_rdata, 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'hABCD;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        check("late_ack_busy", {63'd0, busy}, 64'd0);
        check("late_ack_pulses", {61'd0, dbg_done, dm_rvalid, if_rvalid}, 64'd0);
        check("late_ack_dm_rdata", dm_rdata, 64'd0);
        @(posedge clk); #1;
        if_req = 1; if_addr = 64'hC0;
        accept(3'b001);
        if_req = 0;
        run_txn(2'd3, 2, 1'b0, 64'hC0, 64'd0, 64'h7777, 64'h7777);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
